// File: rtl/cpu_fetch_pkg.sv
// Shared types and widths for the instruction-fetch front end.
package cpu_fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Valid/ready channel carrying fetched instructions and their PCs to decode.
interface fetch_sequencer_if;
  import cpu_fetch_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush empties it and blocks any push in that cycle.
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         full
);

  fetch_entry_t mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == (AW+1)'(DEPTH));
    do_pop   = pop && (count != '0);
    do_push  = push && !flush && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, fetch-enable and RUN/HALT/FAULT control in front of the fetch buffer.
module fetch_sequencer
  import cpu_fetch_pkg::*;
#(
  parameter int                MEM_SIZE   = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_instr,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  fetch_sequencer_if.master   out_if,
  output logic                halted,
  output logic                fault
);

  localparam int                CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] MEM_END = ADDR_W'(MEM_SIZE);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, fault_q;
  logic              push, pop, flush, fifo_full;
  logic [CW-1:0]     fifo_count;
  fetch_entry_t      head;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    pop     = out_if.out_ready && (fifo_count != '0);
    push    = 1'b0;
    flush   = 1'b0;
    pc_d    = pc_q;
    state_d = state_q;
    if (state_q == RUN) begin
      if (redirect) begin
        flush = 1'b1;
        if (is_aligned(redirect_pc)) pc_d    = redirect_pc;
        else                         state_d = FAULT;
      end else if (pc_q + ADDR_W'(3) >= MEM_END) begin
        state_d = HALT;
      end else if (!fifo_full || pop) begin
        push = 1'b1;
        pc_d = pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == HALT);
      fault_q  <= (state_d == FAULT);
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data ('{pc: pc_q, instr: imem_instr}),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  assign imem_addr        = pc_q;
  assign out_if.out_valid = (fifo_count != '0);
  assign out_if.out_instr = head.instr;
  assign out_if.out_pc    = head.pc;
  assign halted           = halted_q;
  assign fault            = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios followed by a randomized run against an instruction-stream model.
module tb_fetch_sequencer;
  import cpu_fetch_pkg::*;

  localparam int MEM_SIZE = 1024;
  localparam int WORDS    = MEM_SIZE / 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        halted, fault;
  logic [31:0] mem [WORDS];
  int          total = 0;
  int          bad   = 0;

  fetch_sequencer_if out_if ();

  fetch_sequencer #(.MEM_SIZE(MEM_SIZE), .RESET_PC(64'd0), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_if      (out_if),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  always_comb imem_instr = (imem_addr < 64'(MEM_SIZE)) ? mem[imem_addr[9:2]] : 32'hdead_beef;

  function automatic logic [63:0] word_at(input logic [63:0] pc);
    return 64'(mem[pc[9:2]]);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [63:0] pc);
    check({tag, "_valid"}, 64'(out_if.out_valid), 64'd1);
    check({tag, "_pc"}, out_if.out_pc, pc);
    check({tag, "_instr"}, 64'(out_if.out_instr), word_at(pc));
  endtask

  logic [63:0] exp_pc;
  logic [63:0] target;
  int          idle;

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    reset            = 1'b1;
    redirect         = 1'b0;
    redirect_pc      = 64'd0;
    out_if.out_ready = 1'b1;

    // Reset for two cycles, then first fetch and steady streaming.
    step();
    step();
    check("rst_valid", 64'(out_if.out_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    reset = 1'b0;
    check("c1_addr", imem_addr, 64'd0);
    check("c1_valid", 64'(out_if.out_valid), 64'd0);
    step();
    check_head("c2", 64'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_head("stream", 64'(4 * k));
    end

    // Backpressure: two pushes then hold; release drains in order.
    out_if.out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) step();
    check("bp_addr", imem_addr, 64'd8);
    check_head("bp_head", 64'd0);
    out_if.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_head("bp_drain", 64'(4 * k));
    end

    // Redirect with a full FIFO and no pop.
    out_if.out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) step();
    redirect = 1'b1; redirect_pc = 64'h40;
    step();
    redirect = 1'b0;
    check("redir_valid", 64'(out_if.out_valid), 64'd0);
    check("redir_addr", imem_addr, 64'h40);
    step();
    check_head("redir_tgt", 64'h40);

    // Redirect on the same cycle the head is consumed: the other entry is dropped.
    do_reset();
    for (int k = 0; k < 3; k++) step();
    check_head("pop_redir_head", 64'd0);
    out_if.out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 64'h80;
    step();
    redirect = 1'b0;
    check("pop_redir_valid", 64'(out_if.out_valid), 64'd0);
    step();
    check_head("pop_redir_tgt", 64'h80);
    step();
    check_head("pop_redir_next", 64'h84);

    // End of memory: last two words delivered, then halt; redirect ignored.
    redirect = 1'b1; redirect_pc = 64'h3F8;
    step();
    redirect = 1'b0;
    step();
    check_head("end_3f8", 64'h3F8);
    step();
    check_head("end_3fc", 64'h3FC);
    step();
    check("end_valid", 64'(out_if.out_valid), 64'd0);
    check("end_halted", 64'(halted), 64'd1);
    check("end_addr", imem_addr, 64'h400);
    redirect = 1'b1; redirect_pc = 64'd0;
    step();
    redirect = 1'b0;
    check("halt_redir_addr", imem_addr, 64'h400);
    check("halt_redir_halted", 64'(halted), 64'd1);

    // Misaligned target faults; later redirects ignored; reset beats redirect.
    do_reset();
    step();
    step();
    redirect = 1'b1; redirect_pc = 64'h42;
    step();
    check("fault_flag", 64'(fault), 64'd1);
    check("fault_valid", 64'(out_if.out_valid), 64'd0);
    check("fault_addr", imem_addr, 64'd8);
    redirect_pc = 64'h40;
    step();
    check("fault_hold_addr", imem_addr, 64'd8);
    check("fault_hold_flag", 64'(fault), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    redirect = 1'b0;
    check("rst_wins_addr", imem_addr, 64'd0);
    check("rst_wins_fault", 64'(fault), 64'd0);
    step();
    check_head("rst_wins_first", 64'd0);

    // Randomized run: delivered stream must follow PC+4 from the last redirect or reset.
    do_reset();
    exp_pc = 64'd0;
    idle   = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (out_if.out_valid) begin
        check("rnd_pc", out_if.out_pc, exp_pc);
        check("rnd_instr", 64'(out_if.out_instr), word_at(exp_pc));
        idle = 0;
      end else if (!halted) begin
        idle++;
        if (idle > 40) begin
          check("rnd_watchdog", 64'(idle), 64'd0);
          idle = 0;
        end
      end
      if (halted && !out_if.out_valid) begin
        check("rnd_halt_next", exp_pc, 64'(MEM_SIZE));
        check("rnd_halt_addr", imem_addr, 64'(MEM_SIZE));
        reset    = 1'b1;
        redirect = 1'b0;
      end else begin
        out_if.out_ready = ($urandom_range(0, 3) != 0);
        redirect = !halted && ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) target = 64'(MEM_SIZE - 4 * $urandom_range(1, 6));
        else                           target = 64'(4 * $urandom_range(0, WORDS - 1));
        redirect_pc = target;
        if (out_if.out_valid && out_if.out_ready) exp_pc = exp_pc + 64'd4;
        if (redirect) exp_pc = target;
      end
      step();
      if (reset) begin
        reset  = 1'b0;
        exp_pc = 64'd0;
        idle   = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
